// File: rtl/eq_band_combiner_if.sv
// eq_band_combiner_if: band-sample handshake, gain write port and result bundle for eq_band_combiner
//   band_in/in_valid/in_ready : packed signed band samples and accept handshake
//   gain_we/gain_addr/gain_wdata : per-band Q2.14 gain register write
//   y_out/out_valid/sat/drop_err : combined result, result pulse, saturation and sticky drop flags
interface eq_band_combiner_if #(
    parameter int NBANDS = 8,
    parameter int DW     = 32,
    parameter int GW     = 16
);
    logic [NBANDS*DW-1:0]      band_in;
    logic                      in_valid;
    logic                      in_ready;
    logic                      gain_we;
    logic [$clog2(NBANDS)-1:0] gain_addr;
    logic signed [GW-1:0]      gain_wdata;
    logic signed [DW-1:0]      y_out;
    logic                      out_valid;
    logic                      sat;
    logic                      drop_err;
    modport master (
        output band_in, in_valid, gain_we, gain_addr, gain_wdata,
        input  in_ready, y_out, out_valid, sat, drop_err
    );
    modport slave (
        input  band_in, in_valid, gain_we, gain_addr, gain_wdata,
        output in_ready, y_out, out_valid, sat, drop_err
    );
endinterface

// File: rtl/eq_band_combiner.sv
// eq_band_combiner: weighted recombination of 8 equalizer bands with one time-multiplexed MAC
//   clk   : system clock, rising edge
//   rst_p : synchronous active-high reset
//   bus   : eq_band_combiner_if.slave (samples in, gain writes, result out)
module eq_band_combiner #(
    parameter int NBANDS = 8,
    parameter int DW     = 32,
    parameter int GW     = 16,
    parameter int FRAC   = 14
) (
    input logic               clk,
    input logic               rst_p,
    eq_band_combiner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;
    localparam int AW = DW + GW + 3;
    localparam int IW = $clog2(NBANDS);
    localparam logic signed [AW-1:0] YMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [AW-1:0] HALF = AW'(1) <<< (FRAC - 1);
    state_t               state_q;
    logic signed [DW-1:0] band_q  [NBANDS];
    logic signed [GW-1:0] gain_q  [NBANDS];
    logic signed [GW-1:0] wgain_q [NBANDS];
    logic signed [AW-1:0] acc_q;
    logic [IW-1:0]        idx_q;
    logic signed [DW-1:0] y_q;
    logic                 ov_q;
    logic                 sat_q;
    logic                 drop_q;
    logic signed [DW+GW-1:0] prod_d;
    logic signed [AW-1:0]    acc_d;
    logic signed [AW-1:0]    rnd_d;
    logic signed [DW-1:0]    y_d;
    logic                    sat_d;
    assign prod_d = band_q[idx_q] * wgain_q[idx_q];
    assign acc_d  = acc_q + {{(AW-DW-GW){prod_d[DW+GW-1]}}, prod_d};
    // Adding half an LSB before the arithmetic shift rounds ties toward +inf
    assign rnd_d  = (acc_q + HALF) >>> FRAC;
    assign sat_d  = (rnd_d > YMAX) || (rnd_d < YMIN);
    assign y_d    = (rnd_d > YMAX) ? YMAX[DW-1:0] : (rnd_d < YMIN) ? YMIN[DW-1:0] : rnd_d[DW-1:0];
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.y_out     = y_q;
    assign bus.out_valid = ov_q;
    assign bus.sat       = sat_q;
    assign bus.drop_err  = drop_q;
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            ov_q    <= 1'b0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
            for (int k = 0; k < NBANDS; k++) begin
                gain_q[k]  <= GW'(1 << FRAC);
                wgain_q[k] <= '0;
                band_q[k]  <= '0;
            end
        end else begin
            ov_q <= 1'b0;
            if (bus.gain_we) gain_q[bus.gain_addr] <= bus.gain_wdata;
            if (bus.in_valid && state_q != IDLE) drop_q <= 1'b1;
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    for (int k = 0; k < NBANDS; k++) band_q[k] <= bus.band_in[k*DW +: DW];
                    // Snapshot uses the pre-write gains; a same-edge write lands in gain_q only
                    wgain_q <= gain_q;
                    acc_q   <= '0;
                    idx_q   <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IW'(NBANDS - 1)) state_q <= ROUND;
                end
                ROUND: begin
                    y_q     <= y_d;
                    sat_q   <= sat_d;
                    ov_q    <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eq_band_combiner.sv
// tb_eq_band_combiner: table-driven plus scoreboard bench for eq_band_combiner
module tb_eq_band_combiner;
    localparam int DW = 32;
    localparam int GW = 16;
    typedef struct {
        logic [7:0][GW-1:0] g;
        logic [7:0][DW-1:0] b;
        logic [DW-1:0]      y;
        logic               s;
    } vec_t;
    typedef struct {
        logic [DW-1:0] y;
        logic          s;
        int            t;
    } exp_t;
    logic clk;
    logic rst_p;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;
    vec_t vt[9];
    eq_band_combiner_if #(.NBANDS(8), .DW(DW), .GW(GW)) bus ();
    eq_band_combiner #(.NBANDS(8), .DW(DW), .GW(GW), .FRAC(14)) dut (
        .clk  (clk),
        .rst_p(rst_p),
        .bus  (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction
    task automatic set_gains(input logic [7:0][GW-1:0] g);
        for (int k = 0; k < 8; k++) begin
            bus.gain_we = 1'b1;
            bus.gain_addr = 3'(k);
            bus.gain_wdata = g[k];
            @(posedge clk); #1;
        end
        bus.gain_we = 1'b0;
    endtask
    task automatic send(input logic [7:0][DW-1:0] b, input logic [DW-1:0] y, input logic s);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready=%0b expected 1", bus.in_ready);
        end
        bus.band_in = b;
        bus.in_valid = 1'b1;
        exp_q.push_back('{y: y, s: s, t: cyc + 1});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL result_timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask
    initial begin
        logic [7:0][DW-1:0] ramp;
        logic [7:0][DW-1:0] b0;
        logic [7:0][GW-1:0] gw;
        logic [7:0][GW-1:0] g0;
        logic ov_seen;
        for (int k = 0; k < 8; k++) ramp[k] = 32'(1000 * (k + 1));
        gw = {8{16'h2000}};
        gw[3] = 16'h0000;
        gw[7] = 16'hC000;
        g0 = '0;
        g0[0] = 16'h2000;
        vt[0] = '{g: {8{16'h4000}}, b: {8{32'd1000}}, y: 32'd8000, s: 1'b0};
        vt[1] = '{g: {8{16'h2000}}, b: ramp, y: 32'd18000, s: 1'b0};
        vt[2] = '{g: gw, b: ramp, y: 32'd4000, s: 1'b0};
        b0 = '0; b0[0] = 32'd3;
        vt[3] = '{g: g0, b: b0, y: 32'd2, s: 1'b0};
        b0[0] = 32'hFFFF_FFFD;
        vt[4] = '{g: g0, b: b0, y: 32'hFFFF_FFFF, s: 1'b0};
        b0[0] = 32'd1;
        vt[5] = '{g: g0, b: b0, y: 32'd1, s: 1'b0};
        vt[6] = '{g: {8{16'h7FFF}}, b: {8{32'h7FFF_FFFF}}, y: 32'h7FFF_FFFF, s: 1'b1};
        vt[7] = '{g: {8{16'h7FFF}}, b: {8{32'h8000_0000}}, y: 32'h8000_0000, s: 1'b1};
        vt[8] = '{g: {8{16'h4000}}, b: {8{32'd1}}, y: 32'd8, s: 1'b0};
        rst_p = 1'b1;
        bus.band_in = '0;
        bus.in_valid = 1'b0;
        bus.gain_we = 1'b0;
        bus.gain_addr = '0;
        bus.gain_wdata = '0;
        fork
            forever begin
                @(negedge clk);
                if (!rst_p && bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: y_out=%0h with no result expected", bus.y_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("y_out", bus.y_out, e.y);
                        chk("sat", 32'(bus.sat), 32'(e.s));
                        chk("latency", 32'(cyc - e.t), 32'd9);
                    end
                end
            end
        join_none
        repeat (2) @(posedge clk);
        #1 rst_p = 1'b0;
        chk("rst_y_out", bus.y_out, 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sat", 32'(bus.sat), 32'd0);
        chk("rst_drop_err", 32'(bus.drop_err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        send({8{32'd1000}}, 32'd8000, 1'b0);
        wait_done();
        for (int i = 0; i < 9; i++) begin
            set_gains(vt[i].g);
            send(vt[i].b, vt[i].y, vt[i].s);
            wait_done();
        end
        chk("drop_err_clear", 32'(bus.drop_err), 32'd0);
        set_gains({8{16'h4000}});
        send({8{32'd1000}}, 32'd8000, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.band_in = {8{32'd5}};
        bus.in_valid = 1'b1;
        bus.gain_we = 1'b1;
        bus.gain_addr = 3'd0;
        bus.gain_wdata = 16'h0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.gain_we = 1'b0;
        chk("drop_err_set", 32'(bus.drop_err), 32'd1);
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        wait_done();
        send({8{32'd1000}}, 32'd7000, 1'b0);
        for (int n = 0; n < 20 && !bus.out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("ready_in_out_valid_cycle", 32'({bus.out_valid, bus.in_ready}), 32'd3);
        bus.band_in = {8{32'd2}};
        bus.in_valid = 1'b1;
        exp_q.push_back('{y: 32'd14, s: 1'b0, t: cyc + 1});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done();
        chk("drop_err_sticky", 32'(bus.drop_err), 32'd1);
        send({8{32'd1000}}, 32'd7000, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_p = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_p = 1'b0;
        ov_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            ov_seen = ov_seen | bus.out_valid;
        end
        chk("abort_no_out_valid", 32'(ov_seen), 32'd0);
        chk("abort_y_out", bus.y_out, 32'd0);
        chk("abort_drop_err", 32'(bus.drop_err), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        send({8{32'd1}}, 32'd8, 1'b0);
        wait_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
